// File: rtl/mmix_flash_reader_if.sv
// rtl/mmix_flash_reader_if.sv - Avalon-MM slave and NOR flash pin bundle for mmix_flash_reader
//
// Purpose: groups the Avalon-MM read/write channel and the flash pin set into one bundle.
// Ports (signals):
//   avs_address[18:0]  octabyte index from the fabric
//   avs_read           read request, held while avs_waitrequest=1
//   avs_write          write request, acknowledged and discarded
//   avs_readdata[63:0] assembled octabyte, lowest-address byte in [63:56]
//   avs_waitrequest    Avalon stall, transfer completes when 0
//   flash_ADDR[21:0]   flash byte address
//   flash_CE_N         chip enable, active low
//   flash_OE_N         output enable, active low
//   flash_WE_N         write enable, held at 1
//   flash_RST_N        flash reset, active low
//   flash_DQ[7:0]      data byte from the flash pads
// Modports:
//   slave  - the controller
//   master - the surrounding environment (fabric master plus flash device)

interface mmix_flash_reader_if;
    logic [18:0] avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [63:0] avs_readdata;
    logic        avs_waitrequest;
    logic [21:0] flash_ADDR;
    logic        flash_CE_N;
    logic        flash_OE_N;
    logic        flash_WE_N;
    logic        flash_RST_N;
    logic [7:0]  flash_DQ;

    modport slave (
        input  avs_address, avs_read, avs_write, flash_DQ,
        output avs_readdata, avs_waitrequest,
               flash_ADDR, flash_CE_N, flash_OE_N, flash_WE_N, flash_RST_N
    );

    modport master (
        output avs_address, avs_read, avs_write, flash_DQ,
        input  avs_readdata, avs_waitrequest,
               flash_ADDR, flash_CE_N, flash_OE_N, flash_WE_N, flash_RST_N
    );
endinterface

// File: rtl/mmix_flash_reader.sv
// rtl/mmix_flash_reader.sv - Read-only Avalon-MM bridge to DE0 byte-mode parallel NOR flash
//
// Purpose: sequences the flash hardware reset after system reset, then turns each Avalon
// read into eight byte-mode flash accesses assembled big-endian into a 64-bit octabyte.
// Writes are acknowledged without touching the flash.
// Parameters:
//   WAIT_CYCLES - clocks each byte address is held before DQ is sampled (>=1)
//   RST_CYCLES  - clocks RST_N is held low, and clocks waited after it rises (>=1)
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - mmix_flash_reader_if.slave (Avalon-MM slave side plus flash pins)

module mmix_flash_reader #(
    parameter int WAIT_CYCLES = 4,
    parameter int RST_CYCLES  = 25
) (
    input  logic                   clk,
    input  logic                   reset,
    mmix_flash_reader_if.slave     bus
);

    // One counter serves both the reset phases and the per-byte wait, so it is sized
    // for the larger of the two reload values.
    localparam int CNT_MAX = (RST_CYCLES > WAIT_CYCLES) ? RST_CYCLES : WAIT_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] RST_LOAD  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        RST_HOLD,
        RST_WAIT,
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [21:0]   r_addr;
    logic          r_ce_n;
    logic          r_oe_n;
    logic          r_rst_n;
    logic [63:0]   r_data;
    logic          r_waitreq;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [21:0]   w_addr_nxt;
    logic          w_ce_n_nxt;
    logic          w_oe_n_nxt;
    logic          w_rst_n_nxt;
    logic [63:0]   w_data_nxt;
    logic          w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RST_HOLD;
            r_cnt     <= RST_LOAD;
            r_idx     <= 3'd0;
            r_addr    <= 22'd0;
            r_ce_n    <= 1'b1;
            r_oe_n    <= 1'b1;
            r_rst_n   <= 1'b0;
            r_data    <= 64'd0;
            r_waitreq <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_addr    <= w_addr_nxt;
            r_ce_n    <= w_ce_n_nxt;
            r_oe_n    <= w_oe_n_nxt;
            r_rst_n   <= w_rst_n_nxt;
            r_data    <= w_data_nxt;
            // Registered so the stall drops in exactly the DONE cycle.
            r_waitreq <= (w_state_nxt != DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_addr_nxt  = r_addr;
        w_ce_n_nxt  = r_ce_n;
        w_oe_n_nxt  = r_oe_n;
        w_rst_n_nxt = r_rst_n;
        w_data_nxt  = r_data;

        unique case (r_state)
            RST_HOLD: begin
                if (w_cnt_zero) begin
                    w_rst_n_nxt = 1'b1;
                    w_cnt_nxt   = RST_LOAD;
                    w_state_nxt = RST_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end

            RST_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end

            IDLE: begin
                // A read takes priority over a simultaneous write.
                if (bus.avs_read) begin
                    w_addr_nxt  = {bus.avs_address, 3'b000};
                    w_ce_n_nxt  = 1'b0;
                    w_oe_n_nxt  = 1'b0;
                    w_idx_nxt   = 3'd0;
                    w_cnt_nxt   = WAIT_LOAD;
                    w_state_nxt = ACCESS;
                end else if (bus.avs_write) begin
                    w_state_nxt = DONE;
                end
            end

            ACCESS: begin
                if (w_cnt_zero) begin
                    // Byte index 0 lands in [63:56]; ~idx*8 gives the low bit of the lane.
                    w_data_nxt[{~r_idx, 3'b000} +: 8] = bus.flash_DQ;
                    if (r_idx != 3'd7) begin
                        w_idx_nxt  = r_idx + 3'd1;
                        // The base is octabyte aligned, so +1 never carries past bit 2.
                        w_addr_nxt = r_addr + 22'd1;
                        w_cnt_nxt  = WAIT_LOAD;
                    end else begin
                        w_ce_n_nxt  = 1'b1;
                        w_oe_n_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = RST_HOLD;
            end
        endcase
    end

    assign bus.avs_readdata    = r_data;
    assign bus.avs_waitrequest = r_waitreq;
    assign bus.flash_ADDR      = r_addr;
    assign bus.flash_CE_N      = r_ce_n;
    assign bus.flash_OE_N      = r_oe_n;
    assign bus.flash_WE_N      = 1'b1;
    assign bus.flash_RST_N     = r_rst_n;

endmodule

// File: doc/mmix_flash_reader.md
# mmix_flash_reader

Read-only controller between the MMIX system's Avalon-MM fabric and the DE0 parallel NOR flash pins (flash_wire ADDR/CE_N/OE_N/WE_N/RST_N/DQ). It sequences the flash hardware reset after system reset. Each Avalon read becomes eight byte-mode flash accesses, assembled big-endian into one 64-bit MMIX octabyte. Writes are acknowledged and discarded.

## Interface

Parameters:
- WAIT_CYCLES, 4, clocks each flash byte address is held before DQ is sampled; must be ≥1; 4 × 20 ns covers 70 ns tACC
- RST_CYCLES, 25, clocks RST_N is held low, and also clocks waited after RST_N rises; must be ≥1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- avs_address  in  19  octabyte index; byte address = {avs_address, 3'b000}
- avs_read  in  1  read request, held by master while avs_waitrequest=1
- avs_write  in  1  write request, ignored apart from handshake
- avs_readdata  out  64  assembled octabyte; byte at lowest address in [63:56]
- avs_waitrequest  out  1  Avalon stall; transfer completes in the cycle it is 0
- flash_ADDR  out  22  flash byte address
- flash_CE_N  out  1  chip enable, active low
- flash_OE_N  out  1  output enable, active low
- flash_WE_N  out  1  write enable; constant 1
- flash_RST_N  out  1  flash reset, active low
- flash_DQ  in  8  flash data byte; pad tristate is handled at the top level

## Operation

- States: RST_HOLD, RST_WAIT, IDLE, ACCESS, DONE. All outputs are registered. avs_waitrequest = (state != DONE).
- Reset values: state=RST_HOLD, flash_RST_N=0, flash_CE_N=1, flash_OE_N=1, flash_WE_N=1, flash_ADDR=0, avs_readdata=0, avs_waitrequest=1, counter=RST_CYCLES-1, byte index=0.
- RST_HOLD: counter decrements. At 0: flash_RST_N←1, counter←RST_CYCLES-1, go to RST_WAIT.
- RST_WAIT: counter decrements. At 0: go to IDLE. Requests arriving during either reset state stall (waitrequest=1).
- IDLE, avs_read=1 (read wins over a simultaneous write):
  - flash_ADDR←{avs_address,3'b000}, CE_N←0, OE_N←0
  - index←0, counter←WAIT_CYCLES-1, go to ACCESS
- IDLE, avs_write=1 only: go to DONE. Flash pins do not change; readdata does not change.
- ACCESS: counter decrements. At 0:
  - avs_readdata[63-8·index -: 8]←flash_DQ
  - index<7: index+1, flash_ADDR+1, counter reloads
  - index=7: CE_N←1, OE_N←1, go to DONE
  - flash_ADDR never wraps: the top octabyte ends at 0x3FFFFF.
- DONE: one cycle with waitrequest=0, then IDLE. The master must deassert or change its request after that cycle. A request still asserted in IDLE starts a new transfer.
- avs_readdata is valid only while waitrequest=0. It is updated byte by byte during ACCESS and holds its value otherwise.
- reset asserted in any state, including mid-ACCESS: the next cycle shows the reset values above, and the full RST_HOLD/RST_WAIT sequence reruns.

## Timing

- Flash reset: flash_RST_N is low for RST_CYCLES cycles after reset deasserts. IDLE is reached 2·RST_CYCLES cycles after deassert (50 with defaults).
- Read, with the request cycle = cycle 0 in IDLE:
  - byte k address is driven cycles kW+1 … (k+1)W, where W = WAIT_CYCLES
  - byte k is sampled at the end of cycle (k+1)W
  - DONE / waitrequest=0 in cycle 8W+1 (cycle 33 with default W)
- Write: waitrequest=0 in cycle 1.
- Back-to-back reads: the next request is accepted in the cycle after DONE. Minimum period 8W+2 cycles.
- CE_N/OE_N stay low continuously across the 8 byte windows and rise in the DONE cycle.

## Test plan

- Reset release, defaults: flash_RST_N=0 for cycles 0–24 after deassert, 1 from cycle 25. A read held from cycle 0 is not accepted before cycle 50. WE_N=1 throughout.
- Read avs_address=0; flash model returns byte=address (0x00…0x07) → flash_ADDR steps 0..7, each held 4 cycles. avs_readdata=0x0001020304050607 with waitrequest=0 exactly in cycle 33.
- Read avs_address=0x7FFFF, model returns 0xF8..0xFF → flash_ADDR 0x3FFFF8..0x3FFFFF with no wrap; readdata=0xF8F9FAFBFCFDFEFF.
- avs_write=1 alone in IDLE → waitrequest=0 in cycle 1. CE_N/OE_N stay 1; readdata unchanged from the previous read.
- avs_read=1 and avs_write=1 together at address 1, model returns 0x08..0x0F → treated as a read: readdata=0x08090A0B0C0D0E0F at cycle 33.
- reset asserted at cycle 10 of a read → next cycle: CE_N=OE_N=1, RST_N=0, readdata=0, waitrequest=1. The reset sequence restarts from cycle 0.
